// File: rtl/gpioemu_mul_core.sv
// Sequential shift-and-add multiplier behind the gpioemu register file: one multiplier bit per clock.
// Optional macro GPIOEMU_MUL_EARLY_EXIT_EN ends CALC once the remaining multiplier bits are all zero.
module gpioemu_mul_core #(
   parameter int WIDTH     = 24,
   parameter int RES_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 n_reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     op_a,
   input  logic [WIDTH-1:0]     op_b,
   output logic                 busy,
   output logic                 done,
   output logic [RES_WIDTH-1:0] result,
   output logic                 overflow,
   output logic [31:0]          op_count
);

   localparam int PW = 2 * WIDTH;
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST_ITER = IW'(WIDTH - 1);

   typedef enum logic {
      S_IDLE,
      S_CALC
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [PW-1:0]         r_acc;
   logic [PW-1:0]         r_mcand;
   logic [WIDTH-1:0]      r_mplier;
   logic [IW-1:0]         r_iter;
   logic                  r_done;
   logic [RES_WIDTH-1:0]  r_result;
   logic                  r_overflow;
   logic [31:0]           r_op_count;

   logic [PW-1:0]         w_acc_sum;
   logic [WIDTH-1:0]      w_mplier_shr;
   logic                  w_last;
   logic                  w_finish;
   logic                  w_load;
   logic                  w_overflow;

   assign w_acc_sum    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign w_mplier_shr = r_mplier >> 1;

`ifdef GPIOEMU_MUL_EARLY_EXIT_EN
   // Remaining multiplier bits all zero: further iterations cannot change acc.
   assign w_last = (r_iter == LAST_ITER) || (w_mplier_shr == '0);
`else
   assign w_last = (r_iter == LAST_ITER);
`endif

   assign w_finish = (r_state == S_CALC) && w_last;
   assign w_load   = (r_state == S_IDLE) && start;

   generate
      if (RES_WIDTH == PW) begin : g_no_ovf
         assign w_overflow = 1'b0;
      end else begin : g_ovf
         assign w_overflow = |w_acc_sum[PW-1:RES_WIDTH];
      end
   endgenerate

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start)  w_state_next = S_CALC;
         S_CALC:  if (w_last) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_acc      <= '0;
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_iter     <= '0;
         r_done     <= 1'b0;
         r_result   <= '0;
         r_overflow <= 1'b0;
         r_op_count <= '0;
      end else begin
         r_done <= w_finish;
         if (w_load) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, op_a};
            r_mplier <= op_b;
            r_iter   <= '0;
         end else if (r_state == S_CALC) begin
            r_acc    <= w_acc_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_shr;
            r_iter   <= r_iter + 1'b1;
         end
         // Published outputs hold until the next finish edge; start never clears them.
         if (w_finish) begin
            r_result   <= w_acc_sum[RES_WIDTH-1:0];
            r_overflow <= w_overflow;
            r_op_count <= r_op_count + 32'd1;
         end
      end
   end

   assign busy     = (r_state == S_CALC);
   assign done     = r_done;
   assign result   = r_result;
   assign overflow = r_overflow;
   assign op_count = r_op_count;

endmodule

// File: doc/gpioemu_mul_core.md
# gpioemu_mul_core

- Sequential shift-and-add multiplier engine; the arithmetic stage directly downstream of the gpioemu register file.
- The register file hands it operand A (0x108) and operand B (0x110) with a start strobe.
- It returns the product for register W (0x118), the completed-operation count for register L (0x120), and the overflow/busy status for register B (0x128).
- One operand bit per clock; no combinational multiplier.

## Interface

Parameters:
- WIDTH, 24, operand width in bits
- RES_WIDTH, 32, width of the result output; must satisfy RES_WIDTH ≤ 2*WIDTH

Ports:
- clk  in  1  system clock; all state changes on rising edge
- n_reset  in  1  asynchronous, active-low reset
- start  in  1  request a multiplication; sampled on rising edge
- op_a  in  WIDTH  multiplicand; sampled with accepted start
- op_b  in  WIDTH  multiplier; sampled with accepted start
- busy  out  1  high while a multiplication is in progress
- done  out  1  one-cycle pulse when result/overflow/op_count are updated
- result  out  RES_WIDTH  low RES_WIDTH bits of last product
- overflow  out  1  high if last product had any set bit above RES_WIDTH-1
- op_count  out  32  number of completed multiplications since reset, wraps 0xFFFFFFFF→0

## Operation

- Internal state:
  - acc (2*WIDTH bits)
  - mcand (2*WIDTH bits, shifted left)
  - mplier (WIDTH bits, shifted right)
  - iter (ceil(log2 WIDTH) bits)
  - state ∈ {IDLE, CALC}
- IDLE:
  - start=1 → load mcand={0,op_a}, mplier=op_b, acc=0, iter=0; go to CALC.
  - start=0 → stay.
- CALC, each edge:
  - If mplier[0], acc += mcand.
  - Then mcand <<= 1, mplier >>= 1, iter++.
  - On the final iteration (iter==WIDTH-1), go to IDLE.
- Finish edge (same edge as the final iteration):
  - result ← (final acc)[RES_WIDTH-1:0]
  - overflow ← |(final acc)[2*WIDTH-1:RES_WIDTH], or 0 when RES_WIDTH==2*WIDTH
  - op_count ← op_count+1
  - done ← 1 for exactly one cycle
- busy = (state==CALC).
- start while busy is ignored: no restart, no operand re-latch, not queued.
- result and overflow hold their value until the next finish edge; they are never cleared by start.
- Full 2*WIDTH-bit product is exact; no truncation before the finish edge.
- Reset (any time, including mid-CALC):
  - state=IDLE, busy=0, done=0, result=0, overflow=0, op_count=0, internal registers=0.
  - The aborted operation produces no done.

## Timing

- Accepted start on edge E → busy=1 after E.
- CALC edges are E+1 … E+WIDTH.
- The finish edge is E+WIDTH (24 with defaults): result/overflow/op_count valid and done=1, busy=0 after it.
- done deasserts after edge E+WIDTH+1.
- Back-to-back operation:
  - start high during the done cycle is accepted (state is IDLE).
  - Throughput is one result per WIDTH+1 cycles with start held high.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration

- GPIOEMU_MUL_EARLY_EXIT_EN defined:
  - CALC also terminates on the edge where the shifted multiplier becomes zero.
  - Latency = max(1, index of highest set bit of op_b + 1) cycles.
  - op_b=0 finishes at E+1 with result 0.
  - Results identical to the fixed-latency build.
- Not defined:
  - Fixed latency of WIDTH cycles for every operand pair.

## Test plan

- Reset, then op_a=2, op_b=7, start one cycle → done at E+24, result=0xE, overflow=0, op_count=1; busy high for exactly 24 cycles.
- op_a=0xED, op_b=0xFA → result=0xE772, overflow=0; then op_a=0, op_b=8 → result=0, overflow=0, op_count=2.
- op_a=op_b=0xFFFFFF → product 0xFFFFFE000001: result=0xFE000001, overflow=1; next op 1×1 → result=1, overflow=0.
- Pulse start again at E+5 with op_a=3, op_b=3 during a running 5×4 → ignored: done once at E+24, result=0x14, op_count incremented by 1 only.
- Assert n_reset=0 at E+10 of a running operation → busy, done, result, op_count all 0 immediately; no done follows; next 1×1 completes with op_count=1.
- With GPIOEMU_MUL_EARLY_EXIT_EN: 2×7 → done at E+3, result=0xE; 5×0 → done at E+1, result=0. Without the macro, both finish at E+24.
